dbus_core_adapter: RTL and testbench
====================================

# dbus_core_adapter

Per-core front end placed between one core's load/store unit and the shared multi-core data-bus arbiter. It accepts one memory request at a time over a valid/ready handshake and converts it into a single-cycle bus request pulse with word-aligned address, byte strobes and lane-replicated store data. It then tracks the bus stall protocol, captures the returned word, and hands the core a sign- or zero-extended load result, or the SC status, over a second valid/ready handshake.

## Interface
- STALL_LIMIT, 1023: stall cycles after which sticky `hang_o` sets; 0 disables the watchdog.
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  adapter can accept
- req_op_i  in  4  operation code (package enum)
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-justified
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  core takes response
- resp_rdata_o  out  32  extended load data / SC status
- resp_err_o  out  1  request rejected, no bus access made
- dbus_re_o, dbus_we_o, dbus_is_lr_o, dbus_is_sc_o  out  1 each  bus request flags
- dbus_addr_o  out  32  word-aligned address; nonzero marks a request
- dbus_wdata_o  out  32  lane-replicated store data
- dbus_wstrb_o  out  4  byte strobes
- dbus_rdata_i  in  32  registered bus read data
- dbus_stall_i  in  1  registered bus stall
- hang_o  out  1  sticky watchdog flag

## Operation
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP.
- IDLE
  - `req_ready_o`=1.
  - On a handshake, latch op, addr and wdata.
  - Go to ISSUE, or go straight to RESP with `resp_err_o`=1 if the request is illegal.
- Illegal requests:
  - `req_addr_i[31:2]`==0, because a zero bus address means "no request".
  - An undefined op.
- ISSUE (exactly one cycle)
  - Drive `dbus_addr_o`={addr[31:2],2'b00}, plus flags, strobes and data.
  - Then go to WAIT_HI.
- All bus outputs are 0 in every state except ISSUE. This is mandatory: any nonzero address while a request is pending is misread as a new request.
- WAIT_HI: wait for `dbus_stall_i`=1, then go to WAIT_LO.
- WAIT_LO
  - In the first cycle `dbus_stall_i`=0, capture `dbus_rdata_i`.
  - Apply load extraction, then go to RESP.
- RESP
  - Hold `resp_valid_o` and data until `resp_ready_i`, then go to IDLE.
  - No new request is accepted in the same cycle.
- Stores:
  - SB: wdata={4{b}}, wstrb=1<<addr[1:0].
  - SH: wdata={2{h}}, wstrb=addr[1]?4'b1100:4'b0011.
  - SW/SC: wstrb=4'hF.
  - `dbus_we_o`=1.
- Loads:
  - LB/LBU select the byte at addr[1:0]; LH/LHU select the half at addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW/LR pass the word through.
  - `dbus_re_o`=1.
- LR: `dbus_re_o`=1 and `dbus_is_lr_o`=1.
- SC:
  - `dbus_we_o`=1 and `dbus_is_sc_o`=1.
  - `resp_rdata_o`=captured word unmodified: 0 means success, 1 means failure.
- Store responses return `resp_rdata_o`=0.
- Watchdog: a counter increments in WAIT_HI/WAIT_LO, saturates at STALL_LIMIT and clears in IDLE. Reaching the limit sets `hang_o`, which clears only on reset. It is observation only and does not change FSM behaviour.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready_o`=1 once reset deasserts.
  - `resp_valid_o`, `resp_err_o`, `resp_rdata_o`, `hang_o` and all dbus outputs =0.
- Reset mid-transaction returns to IDLE immediately. The bus arbiter must be reset concurrently (system-wide reset).
- Acceptance at cycle t gives ISSUE at t+1 and stall high no earlier than t+2.
- Uncontended latency, acceptance to `resp_valid_o`: loads 5 cycles; stores, LR and SC 6 cycles.
- Error responses: `resp_valid_o` at t+1.
- Back-to-back requests: at most one transaction per IDLE visit; minimum one IDLE cycle between transactions.
- `resp_ready_i` held low: response and data stay stable indefinitely.

## Configuration
- `DBUS_ADAPTER_MISALIGN_TRAP_EN`
  - Defined: LH/LHU/SH with addr[0]=1, or LW/SW/LR/SC with addr[1:0]≠0, is rejected in IDLE with `resp_err_o`=1 and no bus access.
  - Undefined: for those ops the low address bits are forced to zero (addr[0] for halves, addr[1:0] for words) and the access proceeds.

## Structure
- Shared package `dbus_pkg`:
  - op enum: LB=0, LH=1, LW=2, LR=3, LBU=4, LHU=5, SB=8, SH=9, SW=10, SC=11.
  - FSM state typedef.
  - Helper constants WSTRB_B/H/W.
- One natural sub-module: `dbus_lane_align`, a combinational store replication/strobe generator and load extract/extend unit, reused for both directions.

## Test plan
- LW to 0x1004, bus returns 0xDEADBEEF with no contention → `resp_rdata_o`=0xDEADBEEF 5 cycles after acceptance; bus request driven for exactly 1 cycle.
- LB to 0x1007 with word 0x80FF_0000 → 0xFFFFFF80; LBU from the same word → 0x00000080.
- SH 0x1234ABCD to 0x1002 → `dbus_wdata_o`=0xABCDABCD, `dbus_wstrb_o`=4'b1100, `dbus_addr_o`=0x1000; `resp_rdata_o`=0.
- SC to 0x2000, bus returns 1 → `resp_rdata_o`=1 with `dbus_is_sc_o` pulsed once.
- Request to 0x0000_0002 → `resp_err_o`=1 at t+1, all dbus outputs stay 0.
- Bus stall held 1100 cycles with STALL_LIMIT=1023 → `hang_o` rises and stays high after the response completes. A separate case asserts reset in WAIT_LO → all outputs 0 the next cycle.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared types and helpers for the per-core data-bus adapter.
// Optional build macro: DBUS_ADAPTER_MISALIGN_TRAP_EN (see dbus_core_adapter).
package dbus_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LH  = 4'd1,
        OP_LW  = 4'd2,
        OP_LR  = 4'd3,
        OP_LBU = 4'd4,
        OP_LHU = 4'd5,
        OP_SB  = 4'd8,
        OP_SH  = 4'd9,
        OP_SW  = 4'd10,
        OP_SC  = 4'd11
    } dbus_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_RESP
    } dbus_state_e;

    localparam logic [3:0] WSTRB_B = 4'b0001;
    localparam logic [3:0] WSTRB_H = 4'b0011;
    localparam logic [3:0] WSTRB_W = 4'b1111;

    function automatic logic op_legal(logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
            4'd8, 4'd9, 4'd10, 4'd11: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

    function automatic logic op_misaligned(logic [3:0] op, logic [1:0] lo);
        case (op)
            OP_LH, OP_LHU, OP_SH:       return lo[0];
            OP_LW, OP_SW, OP_LR, OP_SC: return |lo;
            default:                    return 1'b0;
        endcase
    endfunction

    // Forces the offset bits a half/word access cannot use to zero.
    function automatic logic [31:0] align_addr(logic [3:0] op, logic [31:0] a);
        case (op)
            OP_LH, OP_LHU, OP_SH:       return {a[31:1], 1'b0};
            OP_LW, OP_SW, OP_LR, OP_SC: return {a[31:2], 2'b00};
            default:                    return a;
        endcase
    endfunction

endpackage

// File: rtl/dbus_lane_align.sv
// Combinational lane unit: store replication/strobes toward the bus and
// load byte/half extraction with sign/zero extension back to the core.
module dbus_lane_align
    import dbus_pkg::*;
(
    input  dbus_op_e    op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] rdata_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        wdata_o = 32'd0;
        wstrb_o = 4'd0;
        rdata_o = 32'd0;
        case (op_i)
            OP_SB: begin
                wdata_o = {4{wdata_i[7:0]}};
                wstrb_o = WSTRB_B << addr_lo_i;
            end
            OP_SH: begin
                wdata_o = {2{wdata_i[15:0]}};
                wstrb_o = addr_lo_i[1] ? {WSTRB_H[1:0], 2'b00} : WSTRB_H;
            end
            OP_SW: begin
                wdata_o = wdata_i;
                wstrb_o = WSTRB_W;
            end
            // SC status word comes back untouched: 0 success, 1 failure
            OP_SC: begin
                wdata_o = wdata_i;
                wstrb_o = WSTRB_W;
                rdata_o = rdata_i;
            end
            OP_LB:         rdata_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:        rdata_o = {24'd0, byte_sel};
            OP_LH:         rdata_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:        rdata_o = {16'd0, half_sel};
            OP_LW, OP_LR:  rdata_o = rdata_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/dbus_core_adapter.sv
// Per-core front end to the shared data-bus arbiter: one request in flight,
// single-cycle bus pulse, stall tracking, extended response. Optional macro:
// DBUS_ADAPTER_MISALIGN_TRAP_EN rejects misaligned half/word accesses.
module dbus_core_adapter
    import dbus_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 1023
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [3:0]  req_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        dbus_re_o,
    output logic        dbus_we_o,
    output logic        dbus_is_lr_o,
    output logic        dbus_is_sc_o,
    output logic [31:0] dbus_addr_o,
    output logic [31:0] dbus_wdata_o,
    output logic [3:0]  dbus_wstrb_o,
    input  logic [31:0] dbus_rdata_i,
    input  logic        dbus_stall_i,
    output logic        hang_o
);
    dbus_state_e state_q, state_d;
    dbus_op_e    op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] wd_q, wd_d;
    logic        hang_q, hang_d;

    logic [31:0] al_wdata, al_rdata;
    logic [3:0]  al_wstrb;
    logic        req_bad;

    dbus_lane_align u_align (
        .op_i      (op_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (dbus_rdata_i),
        .wdata_o   (al_wdata),
        .wstrb_o   (al_wstrb),
        .rdata_o   (al_rdata)
    );

    // A zero word address is the bus's "no request" encoding, so it is never issued.
`ifdef DBUS_ADAPTER_MISALIGN_TRAP_EN
    assign req_bad = (req_addr_i[31:2] == 30'd0) || !op_legal(req_op_i)
                     || op_misaligned(req_op_i, req_addr_i[1:0]);
`else
    assign req_bad = (req_addr_i[31:2] == 30'd0) || !op_legal(req_op_i);
`endif

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_err_o   = 1'b0;
        resp_rdata_o = 32'd0;
        dbus_re_o    = 1'b0;
        dbus_we_o    = 1'b0;
        dbus_is_lr_o = 1'b0;
        dbus_is_sc_o = 1'b0;
        dbus_addr_o  = 32'd0;
        dbus_wdata_o = 32'd0;
        dbus_wstrb_o = 4'd0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    op_d    = dbus_op_e'(req_op_i);
`ifdef DBUS_ADAPTER_MISALIGN_TRAP_EN
                    addr_d  = req_addr_i;
`else
                    addr_d  = align_addr(req_op_i, req_addr_i);
`endif
                    wdata_d = req_wdata_i;
                    rdata_d = 32'd0;
                    err_d   = req_bad;
                    state_d = req_bad ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                dbus_addr_o  = {addr_q[31:2], 2'b00};
                dbus_re_o    = !op_q[3];
                dbus_we_o    = op_q[3];
                dbus_is_lr_o = (op_q == OP_LR);
                dbus_is_sc_o = (op_q == OP_SC);
                dbus_wdata_o = al_wdata;
                dbus_wstrb_o = al_wstrb;
                state_d      = S_WAIT_HI;
            end
            S_WAIT_HI: if (dbus_stall_i) state_d = S_WAIT_LO;
            S_WAIT_LO: begin
                if (!dbus_stall_i) begin
                    rdata_d = al_rdata;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                resp_err_o   = err_q;
                resp_rdata_o = rdata_q;
                if (resp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stall watchdog: purely observational, never alters the FSM.
    always_comb begin
        wd_d   = wd_q;
        hang_d = hang_q || (STALL_LIMIT != 0 && wd_q == STALL_LIMIT);
        if (state_q == S_IDLE)
            wd_d = 32'd0;
        else if ((state_q == S_WAIT_HI || state_q == S_WAIT_LO) && wd_q < STALL_LIMIT)
            wd_d = wd_q + 32'd1;
    end

    assign hang_o = hang_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            op_q    <= OP_LB;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            wd_q    <= 32'd0;
            hang_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            hang_q  <= hang_d;
        end
    end

endmodule

// File: tb/tb_dbus_core_adapter.sv
// Directed-vector bench for dbus_core_adapter with a small registered bus model.
module tb_dbus_core_adapter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        re, we, is_lr, is_sc;
    logic [31:0] baddr, bwdata;
    logic [3:0]  bwstrb;
    logic [31:0] brdata;
    logic        bstall;
    logic        hang;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] bus_word = 32'd0;
    int          bus_n = 2;
    int          rem;

    always #5 clk = ~clk;

    dbus_core_adapter #(.STALL_LIMIT(1023)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .dbus_re_o(re), .dbus_we_o(we), .dbus_is_lr_o(is_lr), .dbus_is_sc_o(is_sc),
        .dbus_addr_o(baddr), .dbus_wdata_o(bwdata), .dbus_wstrb_o(bwstrb),
        .dbus_rdata_i(brdata), .dbus_stall_i(bstall), .hang_o(hang)
    );

    // Bus model: stall rises the cycle after the request pulse, holds bus_n cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bstall <= 1'b0;
            brdata <= 32'd0;
            rem    <= 0;
        end else if (baddr != 32'd0) begin
            bstall <= 1'b1;
            rem    <= bus_n - 1;
        end else if (bstall) begin
            if (rem > 0) rem <= rem - 1;
            else begin
                bstall <= 1'b0;
                brdata <= bus_word;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic txn(input string tag, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] word, input int nstall,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                       input logic [31:0] exp_baddr, input logic [31:0] exp_bwdata,
                       input logic [3:0] exp_strb, input logic [3:0] exp_flags);
        logic        got_v;
        int          lat, issues, flag_cyc;
        logic [31:0] r_addr, r_wdata, bus_or, held;
        logic [3:0]  r_strb, r_flags;
        got_v = 1'b0; lat = 0; issues = 0; flag_cyc = 0;
        r_addr = 0; r_wdata = 0; r_strb = 0; r_flags = 0; bus_or = 0;
        @(negedge clk);
        bus_word = word; bus_n = nstall;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        for (int k = 1; k <= 3000 && !got_v; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (baddr != 32'd0) begin
                issues++;
                r_addr = baddr; r_wdata = bwdata; r_strb = bwstrb;
                r_flags = {re, we, is_lr, is_sc};
            end
            if (re || we || is_lr || is_sc) flag_cyc++;
            bus_or |= baddr | bwdata | 32'(bwstrb) | 32'({re, we, is_lr, is_sc});
            if (resp_valid) begin got_v = 1'b1; lat = k; end
        end
        if (!got_v) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_err"}, 32'(resp_err), 32'(exp_err));
        chk({tag, "_rdata"}, resp_rdata, exp_rdata);
        chk({tag, "_issues"}, issues, exp_err ? 0 : 1);
        chk({tag, "_flagcyc"}, flag_cyc, exp_err ? 0 : 1);
        if (exp_err) chk({tag, "_busquiet"}, bus_or, 32'd0);
        else begin
            chk({tag, "_baddr"}, r_addr, exp_baddr);
            chk({tag, "_bwdata"}, r_wdata, exp_bwdata);
            chk({tag, "_bstrb"}, 32'(r_strb), 32'(exp_strb));
            chk({tag, "_bflags"}, 32'(r_flags), 32'(exp_flags));
        end
        held = resp_rdata;
        repeat (2) begin
            @(negedge clk);
            chk({tag, "_hold_v"}, 32'(resp_valid), 32'd1);
            chk({tag, "_hold_d"}, resp_rdata, held);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, "_done_v"}, 32'(resp_valid), 32'd0);
        chk({tag, "_done_rdy"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_addr = 32'd0;
        req_wdata = 32'd0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_baddr", baddr, 32'd0);
        chk("rst_hang", 32'(hang), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);

        //   tag     op     addr          wdata         word          n  rdata         err lat baddr         bwdata        strb     flags
        txn("lw",   4'd2,  32'h1004,     32'h0,        32'hDEADBEEF, 2, 32'hDEADBEEF, 0,  5,  32'h1004,     32'h0,        4'h0,    4'b1000);
        txn("lb",   4'd0,  32'h1007,     32'h0,        32'h80FF0000, 2, 32'hFFFFFF80, 0,  5,  32'h1004,     32'h0,        4'h0,    4'b1000);
        txn("lbu",  4'd4,  32'h1007,     32'h0,        32'h80FF0000, 2, 32'h00000080, 0,  5,  32'h1004,     32'h0,        4'h0,    4'b1000);
        txn("lh",   4'd1,  32'h1006,     32'h0,        32'h80017FFF, 2, 32'hFFFF8001, 0,  5,  32'h1004,     32'h0,        4'h0,    4'b1000);
        txn("lhu",  4'd5,  32'h1004,     32'h0,        32'h80017FFF, 2, 32'h00007FFF, 0,  5,  32'h1004,     32'h0,        4'h0,    4'b1000);
        txn("sh",   4'd9,  32'h1002,     32'h1234ABCD, 32'h0,        3, 32'h0,        0,  6,  32'h1000,     32'hABCDABCD, 4'b1100, 4'b0100);
        txn("sb",   4'd8,  32'h1001,     32'h000000AB, 32'h0,        3, 32'h0,        0,  6,  32'h1000,     32'hABABABAB, 4'b0010, 4'b0100);
        txn("sw",   4'd10, 32'h1008,     32'hCAFEF00D, 32'h55,       3, 32'h0,        0,  6,  32'h1008,     32'hCAFEF00D, 4'hF,    4'b0100);
        txn("sc",   4'd11, 32'h2000,     32'h77,       32'h1,        3, 32'h1,        0,  6,  32'h2000,     32'h77,       4'hF,    4'b0101);
        txn("lr",   4'd3,  32'h2000,     32'h0,        32'h11223344, 3, 32'h11223344, 0,  6,  32'h2000,     32'h0,        4'h0,    4'b1010);
        txn("zaddr",4'd2,  32'h00000002, 32'h0,        32'h0,        2, 32'h0,        1,  1,  32'h0,        32'h0,        4'h0,    4'b0000);
        txn("badop",4'd6,  32'h1000,     32'h0,        32'h0,        2, 32'h0,        1,  1,  32'h0,        32'h0,        4'h0,    4'b0000);
`ifdef DBUS_ADAPTER_MISALIGN_TRAP_EN
        txn("mislw",4'd2,  32'h100A,     32'h0,        32'h0BADF00D, 2, 32'h0,        1,  1,  32'h0,        32'h0,        4'h0,    4'b0000);
`else
        txn("mislw",4'd2,  32'h100A,     32'h0,        32'h0BADF00D, 2, 32'h0BADF00D, 0,  5,  32'h1008,     32'h0,        4'h0,    4'b1000);
`endif

        chk("hang_pre", 32'(hang), 32'd0);
        txn("stall",4'd2,  32'h1000,     32'h0,        32'h12345678, 1100, 32'h12345678, 0, 1103, 32'h1000, 32'h0,       4'h0,    4'b1000);
        chk("hang_post", 32'(hang), 32'd1);
        @(negedge clk);
        chk("hang_sticky", 32'(hang), 32'd1);

        // Reset while the adapter sits in WAIT_LO.
        @(negedge clk);
        bus_n = 50; req_valid = 1'b1; req_op = 4'd2; req_addr = 32'h3000;
        @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_valid", 32'(resp_valid), 32'd0);
        chk("mid_err", 32'(resp_err), 32'd0);
        chk("mid_rdata", resp_rdata, 32'd0);
        chk("mid_baddr", baddr, 32'd0);
        chk("mid_bflags", 32'({re, we, is_lr, is_sc}), 32'd0);
        chk("mid_bdata", bwdata | 32'(bwstrb), 32'd0);
        chk("mid_hang", 32'(hang), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_ready", 32'(req_ready), 32'd1);
        txn("recov",4'd2,  32'h3000,     32'h0,        32'h600DCAFE, 2, 32'h600DCAFE, 0,  5,  32'h3000,     32'h0,        4'h0,    4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
